// File: rtl/gen_read_cmd_q.sv
// Queued read-command serialiser: start bit + {addr,code,par,tag} MSB first; start bit one edge after Trig when idle.
// Busy only stalls frame start; a full queue drops new triggers (sticky Overflow, saturating DropCnt).
module gen_read_cmd_q #(
    parameter int                ADDR_W  = 4,
    parameter logic [ADDR_W-1:0] ADDRESS = 4'b1111,
    parameter int                CODE_W  = 11,
    parameter logic [CODE_W-1:0] CODE    = 11'b11111110010,
    parameter int                TAG_W   = 2,
    parameter bit                ODD_PAR = 1'b0,
    parameter int                QDEPTH  = 4,
    parameter int                GAP     = 2
) (
    input  logic                      Clock,
    input  logic                      Reset,
    input  logic                      Busy,
    input  logic                      Trig,
    input  logic [TAG_W-1:0]          TrigTag,
    input  logic                      ClrErr,
    output logic                      Cmd,
    output logic                      MyBusy,
    output logic                      FrameDone,
    output logic [$clog2(QDEPTH):0]   QCount,
    output logic                      Overflow,
    output logic [7:0]                DropCnt
);

    localparam int N  = ADDR_W + CODE_W + 1 + TAG_W;
    localparam int PW = $clog2(QDEPTH);
    localparam int QW = PW + 1;
    localparam int BW = $clog2(N);
    localparam int GW = $clog2(GAP + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_DONE, ST_GAP} state_t;

    state_t            state_q, state_n;
    logic [TAG_W-1:0]  mem [QDEPTH];
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [TAG_W-1:0]  head_tag;
    logic              par;
    logic              pop, push, drop;
    logic [QW-1:0]     qcount_n;
    logic [N-1:0]      shift_q, shift_n;
    logic [BW-1:0]     bcnt_q, bcnt_n;
    logic [GW-1:0]     gcnt_q, gcnt_n;
    logic              cmd_n;

    // A pop frees a slot in the same edge, so a full queue still accepts a push then.
    assign pop      = (state_q == ST_IDLE) && (QCount != '0) && !Busy;
    assign push     = Trig && ((QCount != QW'(QDEPTH)) || pop);
    assign drop     = Trig && !push;
    assign qcount_n = QCount + QW'(push) - QW'(pop);
    assign head_tag = mem[rd_ptr];
    assign par      = ODD_PAR ? ~^head_tag : ^head_tag;

    always_comb begin
        state_n = state_q;
        cmd_n   = 1'b0;
        shift_n = shift_q;
        bcnt_n  = bcnt_q;
        gcnt_n  = gcnt_q;
        case (state_q)
            ST_IDLE: begin
                if (pop) begin
                    shift_n = {ADDRESS, CODE, par, head_tag};
                    bcnt_n  = '0;
                    cmd_n   = 1'b1;
                    state_n = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                cmd_n   = shift_q[N-1];
                shift_n = {shift_q[N-2:0], 1'b0};
                bcnt_n  = bcnt_q + BW'(1);
                if (bcnt_q == BW'(N - 1))
                    state_n = ST_DONE;
            end
            ST_DONE: begin
                // The DONE cycle is the first of the GAP idle cycles.
                gcnt_n  = GW'(1);
                state_n = (GAP == 1) ? ST_IDLE : ST_GAP;
            end
            ST_GAP: begin
                if (gcnt_q == GW'(GAP - 1))
                    state_n = ST_IDLE;
                else
                    gcnt_n = gcnt_q + GW'(1);
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            bcnt_q    <= '0;
            gcnt_q    <= '0;
            Cmd       <= 1'b0;
            MyBusy    <= 1'b0;
            FrameDone <= 1'b0;
        end else begin
            state_q   <= state_n;
            shift_q   <= shift_n;
            bcnt_q    <= bcnt_n;
            gcnt_q    <= gcnt_n;
            Cmd       <= cmd_n;
            MyBusy    <= (state_n != ST_IDLE) || (qcount_n != '0);
            FrameDone <= (state_q == ST_DONE);
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            QCount <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            QCount <= qcount_n;
        end
    end

    always_ff @(posedge Clock) begin
        if (push) mem[wr_ptr] <= TrigTag;
    end

    // Clear takes priority over a drop in the same cycle.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            Overflow <= 1'b0;
            DropCnt  <= '0;
        end else if (ClrErr) begin
            Overflow <= 1'b0;
            DropCnt  <= '0;
        end else if (drop) begin
            Overflow <= 1'b1;
            if (DropCnt != 8'hFF) DropCnt <= DropCnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_gen_read_cmd_q.sv
// Bench for gen_read_cmd_q: transaction-level queue/stream model checked every cycle,
// plus directed frame captures on a default instance and a TAG_W=3 odd-parity instance.
module tb_gen_read_cmd_q;

    localparam int          TAG_W = 2;
    localparam int          QD    = 4;
    localparam int          GAPC  = 2;
    localparam int          N     = 18;
    localparam logic [3:0]  ADDR  = 4'b1111;
    localparam logic [10:0] CODE  = 11'b11111110010;
    localparam logic [18:0] T1_EXP = {1'b1, 4'b1111, 11'b11111110010, 1'b1, 2'b10};

    logic             Clock = 1'b0;
    logic             Reset = 1'b0;
    logic             Busy = 1'b0, Trig = 1'b0, ClrErr = 1'b0;
    logic [TAG_W-1:0] TrigTag = '0;
    logic             Cmd, MyBusy, FrameDone, Overflow;
    logic [2:0]       QCount;
    logic [7:0]       DropCnt;

    logic       b_busy = 1'b0, b_trig = 1'b0, b_clr = 1'b0;
    logic [2:0] b_tag = '0;
    logic       b_cmd, b_mybusy, b_fd, b_ovf;
    logic [1:0] b_qc;
    logic [7:0] b_drop;

    gen_read_cmd_q dut (
        .Clock(Clock), .Reset(Reset), .Busy(Busy), .Trig(Trig), .TrigTag(TrigTag),
        .ClrErr(ClrErr), .Cmd(Cmd), .MyBusy(MyBusy), .FrameDone(FrameDone),
        .QCount(QCount), .Overflow(Overflow), .DropCnt(DropCnt)
    );

    gen_read_cmd_q #(.TAG_W(3), .ODD_PAR(1'b1), .QDEPTH(2), .GAP(1)) dut5 (
        .Clock(Clock), .Reset(Reset), .Busy(b_busy), .Trig(b_trig), .TrigTag(b_tag),
        .ClrErr(b_clr), .Cmd(b_cmd), .MyBusy(b_mybusy), .FrameDone(b_fd),
        .QCount(b_qc), .Overflow(b_ovf), .DropCnt(b_drop)
    );

    always #5 Clock = ~Clock;

    int n_chk = 0, n_fail = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: tag queue plus a stream of pending {cmd,framedone} output cycles.
    logic [TAG_W-1:0] mq[$];
    logic [1:0]       strm[$];
    logic             e_cmd = 0, e_fd = 0, e_busy = 0, e_ovf = 0;
    int               e_qc = 0, e_drop = 0;
    logic [1:0]       m_el;
    logic [TAG_W-1:0] m_tag;
    logic [N-1:0]     m_word;
    bit               m_dropped;

    always @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            mq.delete(); strm.delete();
            e_cmd = 0; e_fd = 0; e_busy = 0; e_ovf = 0; e_qc = 0; e_drop = 0;
        end else begin
            m_el = 2'b00;
            if (strm.size() > 0) begin
                m_el = strm.pop_front();
            end else if (mq.size() > 0 && !Busy) begin
                m_tag  = mq.pop_front();
                m_word = {ADDR, CODE, ^m_tag, m_tag};
                strm.push_back(2'b10);
                for (int i = N - 1; i >= 0; i--) strm.push_back({m_word[i], 1'b0});
                strm.push_back(2'b01);
                for (int i = 1; i < GAPC; i++) strm.push_back(2'b00);
                m_el = strm.pop_front();
            end
            e_cmd = m_el[1];
            e_fd  = m_el[0];
            m_dropped = 0;
            if (Trig) begin
                if (mq.size() < QD) mq.push_back(TrigTag);
                else m_dropped = 1;
            end
            if (ClrErr) begin
                e_ovf = 0; e_drop = 0;
            end else if (m_dropped) begin
                e_ovf = 1;
                if (e_drop < 255) e_drop++;
            end
            e_busy = (strm.size() > 0) || (mq.size() > 0);
            e_qc   = mq.size();
        end
    end

    int fd_cnt = 0, qc_peak = 0;

    always @(negedge Clock) begin
        chk("cmd", Cmd, e_cmd);
        chk("framedone", FrameDone, e_fd);
        chk("mybusy", MyBusy, e_busy);
        chk("qcount", QCount, e_qc);
        chk("overflow", Overflow, e_ovf);
        chk("dropcnt", DropCnt, e_drop);
        if (FrameDone) fd_cnt++;
        if (int'(QCount) > qc_peak) qc_peak = QCount;
    end

    logic [18:0] frm;
    logic [19:0] frm5, exp5;
    logic        seen;
    logic [2:0]  rtag;

    initial begin
        #1 Reset = 1'b1;
        #2;
        chk("rst_cmd", Cmd, 0);
        chk("rst_mybusy", MyBusy, 0);
        chk("rst_qcount", QCount, 0);
        repeat (3) @(negedge Clock);
        Reset = 1'b0;
        repeat (2) @(negedge Clock);

        // Single frame, exact latency and bit order
        TrigTag = 2'b10; Trig = 1'b1;
        @(posedge Clock); #1 Trig = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 19; k++) begin
            @(posedge Clock); #1;
            frm[18-k] = Cmd;
            seen = seen | FrameDone;
        end
        chk("t1_frame", frm, T1_EXP);
        chk("t1_fd_early", seen, 0);
        @(posedge Clock); #1;
        chk("t1_cmd_end", Cmd, 0);
        chk("t1_fd", FrameDone, 1);
        @(posedge Clock); #1;
        chk("t1_fd_once", FrameDone, 0);
        repeat (5) @(negedge Clock);

        // Busy holds off the frame
        Busy = 1'b1; Trig = 1'b1; TrigTag = 2'b01;
        @(negedge Clock); Trig = 1'b0;
        repeat (9) begin
            @(negedge Clock);
            chk("t2_mybusy", MyBusy, 1);
            chk("t2_cmd", Cmd, 0);
        end
        Busy = 1'b0;
        @(posedge Clock); #1;
        chk("t2_start", Cmd, 1);
        repeat (30) @(negedge Clock);

        // Burst of six triggers into a 4-deep queue
        ClrErr = 1'b1; @(negedge Clock); ClrErr = 1'b0;
        fd_cnt = 0; qc_peak = 0;
        for (int i = 0; i < 6; i++) begin
            Trig = 1'b1; TrigTag = 2'(i % 4);
            @(negedge Clock);
        end
        Trig = 1'b0;
        repeat (150) @(negedge Clock);
        chk("t3_frames", fd_cnt, 5);
        chk("t3_qpeak", qc_peak, 4);
        chk("t3_ovf", Overflow, 1);
        chk("t3_drop", DropCnt, 1);

        // Reset in the middle of a frame with triggers still queued
        Trig = 1'b1; TrigTag = 2'd3; @(negedge Clock);
        TrigTag = 2'd2; @(negedge Clock);
        TrigTag = 2'd1; @(negedge Clock);
        Trig = 1'b0;
        repeat (7) @(posedge Clock);
        #1 chk("t4_busy_pre", MyBusy, 1);
        #1 Reset = 1'b1;
        #1;
        chk("t4_cmd", Cmd, 0);
        chk("t4_mybusy", MyBusy, 0);
        chk("t4_qcount", QCount, 0);
        @(negedge Clock); Reset = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            @(negedge Clock);
            seen = seen | Cmd;
        end
        chk("t4_quiet", seen, 0);

        // Overflow, clear colliding with a drop, saturation
        Busy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            Trig = 1'b1; TrigTag = 2'($urandom);
            @(negedge Clock);
        end
        chk("t6_ovf", Overflow, 1);
        chk("t6_drop", DropCnt, 1);
        ClrErr = 1'b1; @(negedge Clock); ClrErr = 1'b0;
        chk("t6_clr_ovf", Overflow, 0);
        chk("t6_clr_drop", DropCnt, 0);
        repeat (300) @(negedge Clock);
        chk("t6_sat", DropCnt, 255);
        Trig = 1'b0; Busy = 1'b0;
        ClrErr = 1'b1; @(negedge Clock); ClrErr = 1'b0;
        repeat (120) @(negedge Clock);

        // TAG_W=3 odd parity instance
        for (int r = 0; r < 3; r++) begin
            rtag = (r == 0) ? 3'b101 : 3'($urandom);
            exp5 = {1'b1, ADDR, CODE, ~^rtag, rtag};
            b_tag = rtag; b_trig = 1'b1;
            @(posedge Clock); #1 b_trig = 1'b0;
            for (int k = 0; k < 20; k++) begin
                @(posedge Clock); #1;
                frm5[19-k] = b_cmd;
            end
            chk("t5_frame", frm5, exp5);
            @(posedge Clock); #1;
            chk("t5_cmd_end", b_cmd, 0);
            chk("t5_fd", b_fd, 1);
            repeat (3) @(negedge Clock);
        end

        // Randomised traffic
        for (int c = 0; c < 2000; c++) begin
            Trig    = ($urandom_range(0, 2) == 0);
            TrigTag = 2'($urandom);
            Busy    = ($urandom_range(0, 3) == 0);
            ClrErr  = ($urandom_range(0, 49) == 0);
            @(negedge Clock);
        end
        Trig = 1'b0; Busy = 1'b0; ClrErr = 1'b0;
        repeat (120) @(negedge Clock);
        chk("end_idle", MyBusy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
